// File: rtl/predictor_pkg.sv
// Shared types and constants for the branch predictor table and its counter logic.
package predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

endpackage

// File: rtl/sat_ctr2.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module sat_ctr2
    import predictor_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nxt
);

    // Move one step toward the outcome, pinning at the strong ends.
    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != ST)
                nxt = cur + 2'd1;
        end else begin
            if (cur != SNT)
                nxt = cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor_table.sv
// Table of 2-bit counters with optional gshare indexing, registered prediction
// output, resolution-driven training and saturating accuracy statistics.
module branch_predictor_table
    import predictor_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int HIST_BITS  = 6,
    parameter int MODE       = 1,
    parameter int PC_WIDTH   = 32,
    parameter int PC_LSB     = 2,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [PC_WIDTH-1:0]   req_pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_taken,
    input  logic                  upd_pred,
    output logic [HIST_BITS-1:0]  ghr,
    output logic [STAT_WIDTH-1:0] stat_total,
    output logic [STAT_WIDTH-1:0] stat_miss
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    // Kept in flops rather than RAM so reset can clear every entry at once.
    logic [1:0] pht [ENTRIES];

    logic [INDEX_BITS-1:0] req_idx;
    logic [INDEX_BITS-1:0] ghr_ext;
    logic [HIST_BITS-1:0]  ghr_nxt;
    logic [1:0]            upd_cur;
    logic [1:0]            upd_nxt;
    logic                  unused_pc;

    assign unused_pc = ^req_pc;
    assign ghr_ext   = INDEX_BITS'(ghr);
    assign upd_cur   = pht[upd_index];

    always_comb begin
        req_idx = req_pc[PC_LSB +: INDEX_BITS];
        if (MODE == MODE_GSHARE)
            req_idx = req_idx ^ ghr_ext;
    end

    generate
        if (HIST_BITS == 1) begin : g_hist1
            assign ghr_nxt = upd_taken;
        end else begin : g_histn
            assign ghr_nxt = {ghr[HIST_BITS-2:0], upd_taken};
        end
    endgenerate

    sat_ctr2 u_upd_ctr (
        .cur   (upd_cur),
        .taken (upd_taken),
        .nxt   (upd_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                pht[i] <= WNT;
        end else if (upd_valid) begin
            pht[upd_index] <= upd_nxt;
        end
    end

    // Reads see pre-update table and history, so a same-cycle update is not bypassed.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_index <= '0;
        end else begin
            pred_valid <= req_valid;
            if (req_valid) begin
                pred_taken <= pht[req_idx][1];
                pred_index <= req_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr        <= '0;
            stat_total <= '0;
            stat_miss  <= '0;
        end else if (upd_valid) begin
            ghr <= ghr_nxt;
            if (stat_total != '1)
                stat_total <= stat_total + STAT_WIDTH'(1);
            if ((upd_taken != upd_pred) && (stat_miss != '1))
                stat_miss <= stat_miss + STAT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor_table.sv
// Directed bench: a gshare instance and a bimodal instance share stimulus and are
// compared against a reference counter table, history and statistics model.
module tb_branch_predictor_table;

    localparam int IB = 6;
    localparam int HB = 6;
    localparam int SW = 4;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic [31:0]   req_pc;
    logic          upd_valid;
    logic [IB-1:0] upd_index;
    logic          upd_taken;
    logic          upd_pred;

    logic          pred_valid,   pred_valid_b;
    logic          pred_taken,   pred_taken_b;
    logic [IB-1:0] pred_index,   pred_index_b;
    logic [HB-1:0] ghr,          ghr_b;
    logic [SW-1:0] stat_total,   stat_total_b;
    logic [SW-1:0] stat_miss,    stat_miss_b;

    typedef struct {
        logic          taken;
        logic [IB-1:0] idx;
        logic          taken_b;
        logic [IB-1:0] idx_b;
    } exp_t;

    exp_t          sb [$];
    logic [1:0]    m_tbl [64];
    logic [HB-1:0] m_ghr;
    logic [SW-1:0] m_tot;
    logic [SW-1:0] m_miss;
    logic          m_req;
    logic          m_pt, m_pt_b;
    logic [IB-1:0] m_pi, m_pi_b;
    int            checks;
    int            errors;

    branch_predictor_table #(
        .INDEX_BITS(IB), .HIST_BITS(HB), .MODE(1),
        .PC_WIDTH(32), .PC_LSB(2), .STAT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_pc(req_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_index(pred_index),
        .upd_valid(upd_valid), .upd_index(upd_index),
        .upd_taken(upd_taken), .upd_pred(upd_pred),
        .ghr(ghr), .stat_total(stat_total), .stat_miss(stat_miss)
    );

    branch_predictor_table #(
        .INDEX_BITS(IB), .HIST_BITS(HB), .MODE(0),
        .PC_WIDTH(32), .PC_LSB(2), .STAT_WIDTH(SW)
    ) dut_bim (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_pc(req_pc),
        .pred_valid(pred_valid_b), .pred_taken(pred_taken_b), .pred_index(pred_index_b),
        .upd_valid(upd_valid), .upd_index(upd_index),
        .upd_taken(upd_taken), .upd_pred(upd_pred),
        .ghr(ghr_b), .stat_total(stat_total_b), .stat_miss(stat_miss_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // PC whose gshare index (under the current model history) equals idx.
    function automatic logic [31:0] pcFor(input logic [IB-1:0] idx);
        return {24'd0, idx ^ m_ghr, 2'b00};
    endfunction

    task automatic checkOutput();
        exp_t e;
        check("pred_valid", 32'(pred_valid), 32'(m_req));
        check("pred_valid_bim", 32'(pred_valid_b), 32'(m_req));
        if (m_req) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL scoreboard_empty observed 0 expected 1");
            end else begin
                e      = sb.pop_front();
                m_pt   = e.taken;
                m_pi   = e.idx;
                m_pt_b = e.taken_b;
                m_pi_b = e.idx_b;
            end
        end
        check("pred_taken", 32'(pred_taken), 32'(m_pt));
        check("pred_index", 32'(pred_index), 32'(m_pi));
        check("pred_taken_bim", 32'(pred_taken_b), 32'(m_pt_b));
        check("pred_index_bim", 32'(pred_index_b), 32'(m_pi_b));
        check("ghr", 32'(ghr), 32'(m_ghr));
        check("ghr_bim", 32'(ghr_b), 32'(m_ghr));
        check("stat_total", 32'(stat_total), 32'(m_tot));
        check("stat_miss", 32'(stat_miss), 32'(m_miss));
    endtask

    task automatic applyStimulus(input logic r, input logic rq, input logic [31:0] pc,
                                 input logic u, input logic [IB-1:0] ui,
                                 input logic ut, input logic up);
        exp_t e;
        logic [IB-1:0] ib;
        @(negedge clk);
        rst       = r;
        req_valid = rq;
        req_pc    = pc;
        upd_valid = u;
        upd_index = ui;
        upd_taken = ut;
        upd_pred  = up;
        if (r) begin
            for (int i = 0; i < 64; i++)
                m_tbl[i] = 2'b01;
            m_ghr  = '0;
            m_tot  = '0;
            m_miss = '0;
            m_req  = 1'b0;
            m_pt   = 1'b0;
            m_pi   = '0;
            m_pt_b = 1'b0;
            m_pi_b = '0;
            sb.delete();
        end else begin
            m_req = rq;
            if (rq) begin
                ib        = pc[7:2];
                e.idx     = ib ^ m_ghr;
                e.taken   = m_tbl[ib ^ m_ghr][1];
                e.idx_b   = ib;
                e.taken_b = m_tbl[ib][1];
                sb.push_back(e);
            end
            if (u) begin
                if (ut && m_tbl[ui] != 2'b11)
                    m_tbl[ui] = m_tbl[ui] + 2'd1;
                else if (!ut && m_tbl[ui] != 2'b00)
                    m_tbl[ui] = m_tbl[ui] - 2'd1;
                m_ghr = {m_ghr[HB-2:0], ut};
                if (m_tot != '1)
                    m_tot = m_tot + 1'b1;
                if (ut != up && m_miss != '1)
                    m_miss = m_miss + 1'b1;
            end
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_pc    = '0;
        upd_valid = 1'b0;
        upd_index = '0;
        upd_taken = 1'b0;
        upd_pred  = 1'b0;

        // Reset and first prediction
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h40, 0, 0, 0, 0);
        check("t1_index", 32'(pred_index), 32'd16);
        check("t1_taken", 32'(pred_taken), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Saturation of entry 16 in both directions
        applyStimulus(0, 0, 0, 1, 16, 1, 0);
        applyStimulus(0, 0, 0, 1, 16, 1, 0);
        applyStimulus(0, 1, pcFor(16), 0, 0, 0, 0);
        check("t2_taken_after_2t", 32'(pred_taken), 32'd1);
        applyStimulus(0, 0, 0, 1, 16, 1, 1);
        applyStimulus(0, 0, 0, 1, 16, 0, 1);
        applyStimulus(0, 1, pcFor(16), 0, 0, 0, 0);
        check("t2_taken_after_sat", 32'(pred_taken), 32'd1);
        applyStimulus(0, 0, 0, 1, 16, 0, 1);
        applyStimulus(0, 0, 0, 1, 16, 0, 0);
        applyStimulus(0, 1, pcFor(16), 0, 0, 0, 0);
        check("t2_taken_at_00", 32'(pred_taken), 32'd0);
        applyStimulus(0, 0, 0, 1, 16, 0, 0);
        applyStimulus(0, 0, 0, 1, 16, 1, 0);
        applyStimulus(0, 1, pcFor(16), 0, 0, 0, 0);
        check("t2_taken_floor_held", 32'(pred_taken), 32'd0);

        // Gshare history and index
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        check("t3_ghr", 32'(ghr), 32'h06);
        applyStimulus(0, 1, 32'h40, 0, 0, 0, 0);
        check("t3_gshare_index", 32'(pred_index), 32'd22);
        check("t3_bimodal_index", 32'(pred_index_b), 32'd16);

        // Same-cycle request and update read the old entry
        applyStimulus(0, 1, pcFor(9), 1, 9, 1, 0);
        check("t4_read_old", 32'(pred_taken), 32'd0);
        applyStimulus(0, 1, pcFor(9), 0, 0, 0, 0);
        check("t4_read_new", 32'(pred_taken), 32'd1);

        // Statistics saturation
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            applyStimulus(0, 0, 0, 1, IB'(i), i[0], ~i[0]);
        check("t5_total_sat", 32'(stat_total), 32'd15);
        check("t5_miss_sat", 32'(stat_miss), 32'd15);

        // Reset mid-stream discards the in-flight request
        applyStimulus(0, 1, 32'h84, 1, 3, 1, 0);
        applyStimulus(1, 1, 32'h40, 1, 4, 1, 0);
        check("t6_valid_after_rst", 32'(pred_valid), 32'd0);
        check("t6_ghr_after_rst", 32'(ghr), 32'd0);
        check("t6_total_after_rst", 32'(stat_total), 32'd0);
        for (int i = 0; i < 64; i++)
            applyStimulus(0, 1, pcFor(IB'(i)), 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 5, 1, 1);
        applyStimulus(0, 1, pcFor(5), 0, 0, 0, 0);
        check("t6_entry5_from_01", 32'(pred_taken), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
